// File: rtl/h_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : h_pkg
//  Purpose  : Shared types for the hash-table engine h and its command
//             initiator: opcodes, key/value/status types, sequence tag and
//             the response-FIFO entry layout.
//  Revision : 1.0  initial release
// ============================================================================
package h_pkg;

    localparam int K_W        = 8;
    localparam int V_W        = 8;
    localparam int TAG_W_DFLT = 4;

    typedef enum logic [1:0] {
        OP_GET = 2'd0,
        OP_PUT = 2'd1,
        OP_DEL = 2'd2,
        OP_CLR = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_MISS = 2'd1,
        ST_FULL = 2'd2,
        ST_ERR  = 2'd3
    } status_t;

    typedef logic [K_W-1:0]        k_t;
    typedef logic [V_W-1:0]        v_t;
    typedef logic [TAG_W_DFLT-1:0] tag_t;

    typedef struct packed {
        status_t status;
        v_t      v;
        tag_t    tag;
    } rsp_ent_t;

endpackage
`default_nettype wire

// File: rtl/h_cmd_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module   : h_cmd_initiator_if
//  Purpose  : Bundles the four channels around the command initiator:
//             req_*  upstream request (valid/ready)
//             cmd_*  fire-and-forget command to h
//             rsp_*  response beat from h (no backpressure)
//             out_*  in-order tagged response to upstream (valid/ready)
//  Modports : master - the initiator itself; slave - agent + engine side.
//  Revision : 1.0  initial release
// ============================================================================
interface h_cmd_initiator_if #(
    parameter int TAG_W = 4
);
    import h_pkg::*;

    logic             req_vld;
    logic             req_rdy;
    opcode_t          req_opcode;
    k_t               req_k;
    v_t               req_v;

    logic             cmd_vld;
    opcode_t          cmd_opcode;
    k_t               cmd_k;
    v_t               cmd_v;

    logic             rsp_vld;
    status_t          rsp_status;
    v_t               rsp_v;

    logic             out_vld;
    logic             out_rdy;
    status_t          out_status;
    v_t               out_v;
    logic [TAG_W-1:0] out_tag;

    modport master (
        input  req_vld, req_opcode, req_k, req_v,
        output req_rdy,
        output cmd_vld, cmd_opcode, cmd_k, cmd_v,
        input  rsp_vld, rsp_status, rsp_v,
        output out_vld, out_status, out_v, out_tag,
        input  out_rdy
    );

    modport slave (
        output req_vld, req_opcode, req_k, req_v,
        input  req_rdy,
        input  cmd_vld, cmd_opcode, cmd_k, cmd_v,
        output rsp_vld, rsp_status, rsp_v,
        input  out_vld, out_status, out_v, out_tag,
        output out_rdy
    );

endinterface
`default_nettype wire

// File: rtl/h_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : h_fifo
//  Purpose  : Generic synchronous FIFO, registered storage, head visible
//             combinationally on dout.
//  Ports    : clk, arst_n (async active-low), push/din, pop/dout,
//             full, empty.
//  Revision : 1.0  initial release
// ============================================================================
module h_fifo #(
    parameter int W = 8,
    parameter int N = 4          // power of two, >= 2
) (
    input  wire logic         clk,
    input  wire logic         arst_n,
    input  wire logic         push,
    input  wire logic [W-1:0] din,
    input  wire logic         pop,
    output logic      [W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int           AW       = $clog2(N);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(N);

    logic [W-1:0]  mem_q [N];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;

    // Pointers wrap naturally; occupancy carries the extra bit for full.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    a_no_overflow:  assert property (@(posedge clk) disable iff (!arst_n) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!arst_n) !(pop && empty));

endmodule
`default_nettype wire

// File: rtl/h_cmd_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : h_cmd_initiator
//  Purpose  : Drives upstream requests into h's fire-and-forget cmd port,
//             captures every rsp beat and returns responses in order with
//             a sequence tag. A credit counter (in-flight + buffered) caps
//             outstanding work at RSP_DEPTH so no response is ever dropped.
//  Ports    : clk, arst_n (async active-low)
//             bus        - req/cmd/rsp/out channels (master modport)
//             o_inflight - commands issued but not yet responded
//             o_err      - sticky: response arrived with nothing in flight
//  Revision : 1.0  initial release
// ============================================================================
module h_cmd_initiator
    import h_pkg::*;
#(
    parameter int RSP_DEPTH = 4,     // power of two, >= 2
    parameter int TAG_W     = 4
) (
    input  wire logic                           clk,
    input  wire logic                           arst_n,
    h_cmd_initiator_if.master                   bus,
    output logic [$clog2(RSP_DEPTH+1)-1:0]      o_inflight,
    output logic                                o_err
);
    localparam int               CNT_W    = $clog2(RSP_DEPTH+1);
    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(RSP_DEPTH);

    typedef struct packed {
        status_t          status;
        v_t               v;
        logic [TAG_W-1:0] tag;
    } ent_t;
    localparam int ENT_W = $bits(ent_t);

    logic [CNT_W-1:0] cred_q, cred_d;
    logic [CNT_W-1:0] infl_q, infl_d;
    logic [TAG_W-1:0] tag_q,  tag_d;
    logic             err_q,  err_d;
    logic             cmd_vld_q;
    opcode_t          cmd_op_q;
    k_t               cmd_k_q;
    v_t               cmd_v_q;

    logic             accept, rsp_take, rsp_stray, ret;
    logic             tag_full, tag_empty;
    logic [TAG_W-1:0] tag_head;
    logic             rsp_full, rsp_empty;
    logic [ENT_W-1:0] rsp_din, rsp_dout;
    ent_t             rsp_head;

    assign bus.req_rdy = (cred_q != CRED_MAX);
    assign accept      = bus.req_vld & bus.req_rdy;
    assign rsp_take    = bus.rsp_vld & (infl_q != '0);
    assign rsp_stray   = bus.rsp_vld & (infl_q == '0);
    assign ret         = bus.out_vld & bus.out_rdy;

    // The full/empty gates below never act: credits keep the tag FIFO from
    // filling and in-flight != 0 implies a tag is queued.
    h_fifo #(.W(TAG_W), .N(RSP_DEPTH)) u_tag_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (accept & ~tag_full),
        .din    (tag_q),
        .pop    (rsp_take & ~tag_empty),
        .dout   (tag_head),
        .full   (tag_full),
        .empty  (tag_empty)
    );

    assign rsp_din = {bus.rsp_status, bus.rsp_v, tag_head};

    h_fifo #(.W(ENT_W), .N(RSP_DEPTH)) u_rsp_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (rsp_take & ~rsp_full),
        .din    (rsp_din),
        .pop    (ret),
        .dout   (rsp_dout),
        .full   (rsp_full),
        .empty  (rsp_empty)
    );

    assign rsp_head = rsp_dout;

    // Outputs read as zero while nothing is buffered.
    assign bus.out_vld    = ~rsp_empty;
    assign bus.out_status = rsp_empty ? ST_OK : rsp_head.status;
    assign bus.out_v      = rsp_empty ? '0    : rsp_head.v;
    assign bus.out_tag    = rsp_empty ? '0    : rsp_head.tag;

    always_comb begin
        cred_d = cred_q;
        infl_d = infl_q;
        tag_d  = tag_q;
        err_d  = err_q;

        if (accept) tag_d = tag_q + 1'b1;

        case ({accept, ret})
            2'b10:   cred_d = cred_q + 1'b1;
            2'b01:   cred_d = cred_q - 1'b1;
            default: cred_d = cred_q;
        endcase

        case ({accept, rsp_take})
            2'b10:   infl_d = infl_q + 1'b1;
            2'b01:   infl_d = infl_q - 1'b1;
            default: infl_d = infl_q;
        endcase

        if (rsp_stray) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cred_q    <= '0;
            infl_q    <= '0;
            tag_q     <= '0;
            err_q     <= 1'b0;
            cmd_vld_q <= 1'b0;
            cmd_op_q  <= OP_GET;
            cmd_k_q   <= '0;
            cmd_v_q   <= '0;
        end else begin
            cred_q    <= cred_d;
            infl_q    <= infl_d;
            tag_q     <= tag_d;
            err_q     <= err_d;
            cmd_vld_q <= accept;
            if (accept) begin
                cmd_op_q <= bus.req_opcode;
                cmd_k_q  <= bus.req_k;
                cmd_v_q  <= bus.req_v;
            end
        end
    end

    assign bus.cmd_vld    = cmd_vld_q;
    assign bus.cmd_opcode = cmd_op_q;
    assign bus.cmd_k      = cmd_k_q;
    assign bus.cmd_v      = cmd_v_q;
    assign o_inflight     = infl_q;
    assign o_err          = err_q;

    a_rsp_no_overflow: assert property (@(posedge clk) disable iff (!arst_n) !(rsp_take && rsp_full));

endmodule
`default_nettype wire

// File: tb/tb_h_cmd_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_h_cmd_initiator
//  Purpose  : Directed self-checking bench for h_cmd_initiator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_h_cmd_initiator;
    import h_pkg::*;

    localparam int RSP_DEPTH = 4;
    localparam int TAG_W     = 4;
    localparam int CNT_W     = $clog2(RSP_DEPTH+1);

    logic             clk = 1'b0;
    logic             arst_n;
    logic [CNT_W-1:0] o_inflight;
    logic             o_err;

    int total = 0;
    int bad   = 0;

    h_cmd_initiator_if #(.TAG_W(TAG_W)) bus ();

    h_cmd_initiator #(.RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .bus        (bus),
        .o_inflight (o_inflight),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic idle_inputs;
        bus.req_vld    = 1'b0;
        bus.req_opcode = OP_GET;
        bus.req_k      = '0;
        bus.req_v      = '0;
        bus.rsp_vld    = 1'b0;
        bus.rsp_status = ST_OK;
        bus.rsp_v      = '0;
        bus.out_rdy    = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        arst_n = 1'b0;
        #3;
        arst_n = 1'b1;
        tick();
    endtask

    function automatic logic [7:0] v_of(input int i);
        return 8'(i * 7 + 3);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        logic       d1_vld;
        logic [7:0] d1_v;

        // ---------------- reset state ----------------
        idle_inputs();
        arst_n = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
        tick();
        chk("rst_req_rdy",  32'(bus.req_rdy), 32'(1));
        chk("rst_cmd_vld",  32'(bus.cmd_vld), 32'(0));
        chk("rst_out_vld",  32'(bus.out_vld), 32'(0));
        chk("rst_inflight", 32'(o_inflight),  32'(0));
        chk("rst_err",      32'(o_err),       32'(0));
        chk("rst_cmd_k",    32'(bus.cmd_k),   32'(0));
        chk("rst_out_tag",  32'(bus.out_tag), 32'(0));

        // ---------------- single request ----------------
        bus.req_vld    = 1'b1;
        bus.req_opcode = OP_PUT;
        bus.req_k      = 8'h12;
        bus.req_v      = 8'h34;
        tick();
        bus.req_vld = 1'b0;
        chk("single_cmd_vld", 32'(bus.cmd_vld),    32'(1));
        chk("single_cmd_op",  32'(bus.cmd_opcode), 32'(OP_PUT));
        chk("single_cmd_k",   32'(bus.cmd_k),      32'h12);
        chk("single_cmd_v",   32'(bus.cmd_v),      32'h34);
        chk("single_infl",    32'(o_inflight),     32'(1));
        tick();
        chk("single_pulse",   32'(bus.cmd_vld),    32'(0));
        chk("single_hold_k",  32'(bus.cmd_k),      32'h12);
        tick();
        bus.rsp_vld    = 1'b1;
        bus.rsp_status = ST_OK;
        bus.rsp_v      = 8'h34;
        tick();
        bus.rsp_vld = 1'b0;
        chk("single_out_vld", 32'(bus.out_vld),    32'(1));
        chk("single_out_tag", 32'(bus.out_tag),    32'(0));
        chk("single_out_v",   32'(bus.out_v),      32'h34);
        chk("single_out_st",  32'(bus.out_status), 32'(ST_OK));
        chk("single_infl0",   32'(o_inflight),     32'(0));
        tick();
        chk("single_stable",  32'(bus.out_v),      32'h34);
        bus.out_rdy = 1'b1;
        tick();
        bus.out_rdy = 1'b0;
        chk("single_popped",  32'(bus.out_vld),    32'(0));

        // ---------------- credit exhaustion ----------------
        do_reset();
        bus.req_opcode = OP_GET;
        for (int i = 0; i < 5; i++) begin
            bus.req_vld = (i < 4);
            bus.req_k   = 8'(8'h40 + i);
            bus.req_v   = 8'(i);
            bus.rsp_vld = (i > 0);
            bus.rsp_v   = 8'(8'hA0 + i - 1);
            tick();
            chk("exh_req_rdy", 32'(bus.req_rdy), 32'(i < 3));
        end
        bus.rsp_vld = 1'b0;
        bus.req_vld = 1'b1;
        bus.req_k   = 8'h44;
        tick();
        chk("exh_rdy_stays0", 32'(bus.req_rdy), 32'(0));
        chk("exh_infl",       32'(o_inflight),  32'(0));
        chk("exh_head_tag",   32'(bus.out_tag), 32'(0));
        chk("exh_head_v",     32'(bus.out_v),   32'hA0);
        bus.out_rdy = 1'b1;
        tick();
        bus.out_rdy = 1'b0;
        bus.req_vld = 1'b0;
        chk("exh_rdy_back",   32'(bus.req_rdy), 32'(1));
        chk("exh_no_cmd",     32'(bus.cmd_vld), 32'(0));
        bus.out_rdy = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("exh_drain_vld", 32'(bus.out_vld), 32'(1));
            chk("exh_drain_tag", 32'(bus.out_tag), 32'(1 + j));
            chk("exh_drain_v",   32'(bus.out_v),   32'(8'hA1 + j));
            tick();
        end
        bus.out_rdy = 1'b0;
        chk("exh_empty", 32'(bus.out_vld), 32'(0));

        // ---------------- back-to-back streaming ----------------
        do_reset();
        sent   = 0;
        got    = 0;
        d1_vld = 1'b0;
        d1_v   = '0;
        bus.out_rdy    = 1'b1;
        bus.rsp_status = ST_OK;
        for (int c = 0; c < 30; c++) begin
            bus.req_vld = (sent < 20);
            bus.req_k   = 8'(sent);
            bus.req_v   = v_of(sent);
            if (sent < 20) chk("stream_rdy", 32'(bus.req_rdy), 32'(1));
            tick();
            if (bus.req_vld) sent++;
            if (c <= 20) chk("stream_cmd", 32'(bus.cmd_vld), 32'(c < 20));
            // h model: echo the command value one cycle after seeing it
            bus.rsp_vld = d1_vld;
            bus.rsp_v   = d1_v;
            d1_vld      = bus.cmd_vld;
            d1_v        = bus.cmd_v;
            if (bus.out_vld) begin
                chk("stream_tag", 32'(bus.out_tag), 32'(got % 16));
                chk("stream_v",   32'(bus.out_v),   32'(v_of(got)));
                got++;
            end
        end
        idle_inputs();
        chk("stream_count", 32'(got),        32'(20));
        chk("stream_infl",  32'(o_inflight), 32'(0));

        // ---------------- simultaneous events ----------------
        do_reset();
        bus.req_vld = 1'b1;
        bus.req_k   = 8'h01;
        bus.req_v   = 8'h11;
        tick();
        bus.req_k      = 8'h02;
        bus.req_v      = 8'h22;
        bus.rsp_vld    = 1'b1;
        bus.rsp_status = ST_MISS;
        bus.rsp_v      = 8'h55;
        tick();
        chk("sim_pre_cred", 32'(dut.cred_q),     32'(2));
        chk("sim_pre_infl", 32'(o_inflight),     32'(1));
        chk("sim_pre_tag",  32'(bus.out_tag),    32'(0));
        chk("sim_pre_st",   32'(bus.out_status), 32'(ST_MISS));
        bus.req_k      = 8'h03;
        bus.req_v      = 8'h33;
        bus.rsp_status = ST_OK;
        bus.rsp_v      = 8'h66;
        bus.out_rdy    = 1'b1;
        tick();
        chk("sim_cred",    32'(dut.cred_q),  32'(2));
        chk("sim_infl",    32'(o_inflight),  32'(1));
        chk("sim_out_tag", 32'(bus.out_tag), 32'(1));
        chk("sim_out_v",   32'(bus.out_v),   32'h66);
        chk("sim_cmd_k",   32'(bus.cmd_k),   32'h03);
        bus.req_vld    = 1'b0;
        bus.out_rdy    = 1'b0;
        bus.rsp_status = ST_FULL;
        bus.rsp_v      = 8'h77;
        tick();
        bus.rsp_vld = 1'b0;
        chk("sim_infl0",  32'(o_inflight),  32'(0));
        chk("sim_hold",   32'(bus.out_tag), 32'(1));
        bus.out_rdy = 1'b1;
        tick();
        chk("sim_last_tag", 32'(bus.out_tag),    32'(2));
        chk("sim_last_v",   32'(bus.out_v),      32'h77);
        chk("sim_last_st",  32'(bus.out_status), 32'(ST_FULL));
        tick();
        bus.out_rdy = 1'b0;
        chk("sim_drained", 32'(dut.cred_q), 32'(0));

        // ---------------- unexpected response ----------------
        bus.rsp_vld = 1'b1;
        bus.rsp_v   = 8'h99;
        tick();
        bus.rsp_vld = 1'b0;
        chk("stray_err",     32'(o_err),       32'(1));
        chk("stray_out_vld", 32'(bus.out_vld), 32'(0));
        chk("stray_infl",    32'(o_inflight),  32'(0));
        tick();
        tick();
        chk("stray_sticky",  32'(o_err),       32'(1));

        // ---------------- reset mid-operation ----------------
        bus.req_vld = 1'b1;
        bus.req_k   = 8'h5A;
        bus.req_v   = 8'hAB;
        tick();
        bus.rsp_vld = 1'b1;
        bus.rsp_v   = 8'hCD;
        tick();
        bus.req_vld = 1'b0;
        bus.rsp_vld = 1'b0;
        chk("mid_pre_out", 32'(bus.out_vld), 32'(1));
        chk("mid_pre_cmd", 32'(bus.cmd_vld), 32'(1));
        arst_n = 1'b0;
        #1;
        chk("mid_cmd_vld", 32'(bus.cmd_vld), 32'(0));
        chk("mid_out_vld", 32'(bus.out_vld), 32'(0));
        chk("mid_err",     32'(o_err),       32'(0));
        chk("mid_infl",    32'(o_inflight),  32'(0));
        chk("mid_req_rdy", 32'(bus.req_rdy), 32'(1));
        chk("mid_cmd_k",   32'(bus.cmd_k),   32'(0));
        chk("mid_out_v",   32'(bus.out_v),   32'(0));
        chk("mid_cred",    32'(dut.cred_q),  32'(0));
        #2;
        arst_n = 1'b1;
        tick();
        chk("post_out_vld", 32'(bus.out_vld), 32'(0));
        chk("post_req_rdy", 32'(bus.req_rdy), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
